// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM-then-MEM/WB operand forwarding.
// Stage registers update with priority flush > stall > load; forwarding is purely combinational.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [2:0]    id_alu_ctrl,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_branch,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_dst,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic          ex_reg_write,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_branch,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt
);

    localparam logic [2:0] ALU_ADD = 3'b010;

    logic [DW-1:0] rd1_q;
    logic [DW-1:0] rd2_q;
    logic [DW-1:0] imm_q;
    logic          alu_src_q;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // A bubble keeps alu_ctrl at add so the ALU sees a benign opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            alu_ctrl      <= ALU_ADD;
            alu_src_q     <= 1'b0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dst        <= '0;
        end else if (flush) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            alu_ctrl      <= ALU_ADD;
            alu_src_q     <= 1'b0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dst        <= '0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_reg_write  <= id_reg_write;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_branch     <= id_branch;
            alu_ctrl      <= id_alu_ctrl;
            alu_src_q     <= id_alu_src;
            rd1_q         <= id_rd1;
            rd2_q         <= id_rd2;
            imm_q         <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_dst        <= id_reg_dst ? id_rd : id_rt;
        end
    end

    // The younger producer (EX/MEM) wins; register 0 never forwards.
    always_comb begin
        fwd_rs = rd1_q;
        if (exm_reg_write && (exm_dst == ex_rs) && (exm_dst != '0))
            fwd_rs = exm_result;
        else if (wb_reg_write && (wb_dst == ex_rs) && (wb_dst != '0))
            fwd_rs = wb_result;

        fwd_rt = rd2_q;
        if (exm_reg_write && (exm_dst == ex_rt) && (exm_dst != '0))
            fwd_rt = exm_result;
        else if (wb_reg_write && (wb_dst == ex_rt) && (wb_dst != '0))
            fwd_rt = wb_result;
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus a randomized stream checked
// against an instruction-level model of the stage contents.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        stall, flush;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_write, id_mem_to_reg, id_branch;
    logic        exm_reg_write, wb_reg_write;
    logic [4:0]  exm_dst, wb_dst;
    logic [31:0] exm_result, wb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_ctrl;
    logic [4:0]  ex_dst, ex_rs, ex_rt;
    logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_branch, ex_valid;

    int total = 0;
    int bad   = 0;

    id_ex_operand_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exm_reg_write(exm_reg_write), .exm_dst(exm_dst), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_valid(ex_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // The instruction currently held in EX, as the architecture describes it.
    typedef struct {
        bit          valid, rw, mw, m2r, br, src;
        logic [2:0]  ctrl;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, dst;
    } instr_t;

    instr_t m;

    function automatic instr_t empty_instr();
        instr_t e;
        e.valid = 0; e.rw = 0; e.mw = 0; e.m2r = 0; e.br = 0; e.src = 0;
        e.ctrl = 3'b010; e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.rs = 0; e.rt = 0; e.dst = 0;
        return e;
    endfunction

    // Value the EX stage should see for a source register right now.
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (exm_reg_write && exm_dst == idx) return exm_result;
        if (wb_reg_write && wb_dst == idx) return wb_result;
        return rf;
    endfunction

    // Advance one clock edge and update the model from what ID presented.
    task automatic step();
        @(posedge clk);
        if (!rst_n) m = empty_instr();
        else if (flush) m = empty_instr();
        else if (!stall) begin
            m.valid = 1; m.rw = id_reg_write; m.mw = id_mem_write; m.m2r = id_mem_to_reg;
            m.br = id_branch; m.src = id_alu_src; m.ctrl = id_alu_ctrl;
            m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm; m.rs = id_rs; m.rt = id_rt;
            m.dst = id_reg_dst ? id_rd : id_rt;
        end
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_id(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [2:0] ctrl, input logic src, input logic regdst,
                            input logic [3:0] ctl4);
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
        id_alu_ctrl = ctrl; id_alu_src = src; id_reg_dst = regdst;
        {id_reg_write, id_mem_write, id_mem_to_reg, id_branch} = ctl4;
    endtask

    task automatic drive_random_id(input int idx_max);
        drive_id($urandom, $urandom, $urandom, 5'($urandom_range(0, idx_max)),
                 5'($urandom_range(0, idx_max)), 5'($urandom_range(0, idx_max)),
                 3'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] edst, input logic [31:0] eres,
                           input logic wrw, input logic [4:0] wdst, input logic [31:0] wres);
        exm_reg_write = erw; exm_dst = edst; exm_result = eres;
        wb_reg_write = wrw; wb_dst = wdst; wb_result = wres;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; stall = 0; flush = 0;
        drive_random_id(31);
        set_fwd(1, 0, $urandom, 1, 0, $urandom);
        m = empty_instr();
        repeat (3) step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ex_valid); end
        total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL reset_reg_write got=%0b want=0", ex_reg_write); end
        total++; if (alu_ctrl !== 3'b010) begin bad++; $display("FAIL reset_alu_ctrl got=%b want=010", alu_ctrl); end
        total++; if (ex_dst !== 5'd0) begin bad++; $display("FAIL reset_dst got=%0d want=0", ex_dst); end
        total++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin bad++; $display("FAIL reset_operands got=%h/%h want=0/0", alu_a, alu_b); end
        @(negedge clk);
        rst_n = 1;
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b1, 4'b1000);
        step();
        total++; if (alu_a !== 32'd5) begin bad++; $display("FAIL first_alu_a got=%h want=5", alu_a); end
        total++; if (alu_b !== 32'd7) begin bad++; $display("FAIL first_alu_b got=%h want=7", alu_b); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b want=1", ex_valid); end
    endtask

    task automatic test_forward_priority();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(32'h100, 32'h200, 32'h0, 5'd3, 5'd3, 5'd7, 3'b000, 1'b0, 1'b0, 4'b0000);
        step();
        set_fwd(1, 3, 32'hAAAA0000, 1, 3, 32'h11111111);
        #1;
        total++; if (alu_a !== 32'hAAAA0000 || alu_b !== 32'hAAAA0000) begin
            bad++; $display("FAIL fwd_exm got=%h/%h want=aaaa0000", alu_a, alu_b); end
        exm_reg_write = 0;
        #1;
        total++; if (alu_a !== 32'h11111111 || alu_b !== 32'h11111111) begin
            bad++; $display("FAIL fwd_wb got=%h/%h want=11111111", alu_a, alu_b); end
        wb_reg_write = 0;
        #1;
        total++; if (alu_a !== 32'h100 || alu_b !== 32'h200) begin
            bad++; $display("FAIL fwd_none got=%h/%h want=100/200", alu_a, alu_b); end
        exm_reg_write = 1; exm_dst = 5'd4;
        #1;
        total++; if (alu_a !== 32'h100) begin bad++; $display("FAIL fwd_dst_miss got=%h want=100", alu_a); end
    endtask

    task automatic test_reg0();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 4'b0000);
        step();
        set_fwd(1, 0, 32'hDEADBEEF, 1, 0, 32'hCAFEF00D);
        #1;
        total++; if (alu_a !== 32'h0) begin bad++; $display("FAIL reg0_alu_a got=%h want=0", alu_a); end
        total++; if (ex_store_data !== 32'h0) begin bad++; $display("FAIL reg0_store got=%h want=0", ex_store_data); end
    endtask

    task automatic test_imm();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(32'h1, 32'h77, 32'hFFFFFFFC, 5'd2, 5'd6, 5'd0, 3'b010, 1'b1, 1'b0, 4'b0100);
        step();
        set_fwd(1, 6, 32'h55, 0, 0, 0);
        #1;
        total++; if (alu_b !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_alu_b got=%h want=fffffffc", alu_b); end
        total++; if (ex_store_data !== 32'h55) begin bad++; $display("FAIL imm_store got=%h want=55", ex_store_data); end
    endtask

    task automatic test_stall_flush();
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(32'h1111, 32'h2222, 32'h0, 5'd8, 5'd9, 5'd10, 3'b101, 1'b0, 1'b1, 4'b1100);
        step();
        drive_id(32'h3333, 32'h4444, 32'h0, 5'd11, 5'd12, 5'd13, 3'b110, 1'b0, 1'b1, 4'b1010);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (alu_a !== 32'h1111 || alu_ctrl !== 3'b101 || ex_valid !== 1'b1 || ex_dst !== 5'd10) begin
                bad++; $display("FAIL stall_hold%0d got a=%h ctrl=%b v=%0b dst=%0d want a=1111 ctrl=101 v=1 dst=10",
                                i, alu_a, alu_ctrl, ex_valid, ex_dst); end
        end
        set_fwd(1, 8, 32'h9999, 0, 0, 0);
        #1;
        total++; if (alu_a !== 32'h9999) begin bad++; $display("FAIL stall_fwd got=%h want=9999", alu_a); end
        set_fwd(0, 0, 0, 0, 0, 0);
        flush = 1;
        step();
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || alu_ctrl !== 3'b010) begin
            bad++; $display("FAIL stall_flush got v=%0b rw=%0b mw=%0b ctrl=%b want 0 0 0 010",
                            ex_valid, ex_reg_write, ex_mem_write, alu_ctrl); end
        stall = 0; flush = 0;
        step();
        total++; if (alu_a !== 32'h3333 || alu_ctrl !== 3'b110 || ex_valid !== 1'b1 || ex_dst !== 5'd13 || ex_mem_to_reg !== 1'b1) begin
            bad++; $display("FAIL after_flush got a=%h ctrl=%b v=%0b dst=%0d want a=3333 ctrl=110 v=1 dst=13",
                            alu_a, alu_ctrl, ex_valid, ex_dst); end
    endtask

    task automatic test_dst();
        drive_id(32'h0, 32'h0, 32'h0, 5'd1, 5'd4, 5'd9, 3'b000, 1'b0, 1'b1, 4'b1000);
        step();
        total++; if (ex_dst !== 5'd9) begin bad++; $display("FAIL dst_rd got=%0d want=9", ex_dst); end
        id_reg_dst = 0;
        step();
        total++; if (ex_dst !== 5'd4) begin bad++; $display("FAIL dst_rt got=%0d want=4", ex_dst); end
    endtask

    task automatic test_reset_mid_stall();
        drive_id(32'hAB, 32'hCD, 32'h0, 5'd5, 5'd6, 5'd7, 3'b111, 1'b0, 1'b1, 4'b1111);
        step();
        stall = 1;
        step();
        #2;
        rst_n = 0;
        m = empty_instr();
        #1;
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_branch !== 1'b0 || alu_ctrl !== 3'b010 || ex_dst !== 5'd0) begin
            bad++; $display("FAIL async_reset got v=%0b rw=%0b br=%0b ctrl=%b dst=%0d want 0 0 0 010 0",
                            ex_valid, ex_reg_write, ex_branch, alu_ctrl, ex_dst); end
        @(negedge clk);
        rst_n = 1; stall = 0;
        step();
        total++; if (ex_valid !== 1'b1 || alu_a !== 32'hAB) begin
            bad++; $display("FAIL restart got v=%0b a=%h want v=1 a=ab", ex_valid, alu_a); end
    endtask

    task automatic test_random();
        logic [31:0] exp_b;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive_random_id(3);
            step();
            for (int k = 0; k < 2; k++) begin
                set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                        1'($urandom), 5'($urandom_range(0, 3)), $urandom);
                #1;
                exp_b = m.src ? m.imm : fwd(m.rt, m.rd2);
                total++; if (alu_a !== fwd(m.rs, m.rd1)) begin
                    bad++; $display("FAIL rnd_alu_a c=%0d got=%h want=%h", c, alu_a, fwd(m.rs, m.rd1)); end
                total++; if (alu_b !== exp_b) begin
                    bad++; $display("FAIL rnd_alu_b c=%0d got=%h want=%h", c, alu_b, exp_b); end
                total++; if (ex_store_data !== fwd(m.rt, m.rd2)) begin
                    bad++; $display("FAIL rnd_store c=%0d got=%h want=%h", c, ex_store_data, fwd(m.rt, m.rd2)); end
            end
            total++; if ({ex_valid, ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_branch} !== {m.valid, m.rw, m.mw, m.m2r, m.br}) begin
                bad++; $display("FAIL rnd_ctl c=%0d got=%b want=%b", c,
                                {ex_valid, ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_branch},
                                {m.valid, m.rw, m.mw, m.m2r, m.br}); end
            total++; if ({alu_ctrl, ex_dst, ex_rs, ex_rt} !== {m.ctrl, m.dst, m.rs, m.rt}) begin
                bad++; $display("FAIL rnd_fields c=%0d got ctrl=%b dst=%0d rs=%0d rt=%0d want ctrl=%b dst=%0d rs=%0d rt=%0d",
                                c, alu_ctrl, ex_dst, ex_rs, ex_rt, m.ctrl, m.dst, m.rs, m.rt); end
        end
        stall = 0; flush = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_forward_priority();
        test_reg0();
        test_imm();
        test_stall_flush();
        test_dst();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
